// File: rtl/md_rs_pkg.sv
// Shared types and constants for the mul/div reservation station.
//   rs_state_e : per-entry lifecycle FREE -> WAIT/READY -> EXEC -> FREE
//   rs_entry_t : stored payload of one station entry
package md_rs_pkg;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_DIV = 4'b0011;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [TAG_W-1:0]  rob;
        logic              qj_busy;
        logic              qk_busy;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
    } rs_entry_t;
endpackage

// File: rtl/md_rs_pick.sv
// Lowest-index priority encoder.
//   i_req   : request vector, bit i = candidate i
//   o_found : any request set
//   o_idx   : index of the lowest set request (0 when none)
module md_rs_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/md_reservation_station.sv
// Reservation station in front of the shared mul/div unit.
//   clk/rst            : clock, synchronous active-high reset
//   flush              : drop all entries and the in-flight operation
//   disp_*             : dispatch request (ctrl, rob tag, operand tags/values)
//   cdb_*              : common data bus broadcast, snooped by waiting entries
//   data_ready,x,y,... : one-cycle issue pulse plus held operands to the unit
//   alu_done/save_no   : completion from the unit, frees the matching entry
module md_reservation_station
    import md_rs_pkg::*;
#(
    parameter int ENTRIES      = 4,
    parameter int STATION_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [CTRL_W-1:0] disp_ctrl,
    input  logic [TAG_W-1:0]  disp_rob,
    input  logic              disp_qj_busy,
    input  logic              disp_qk_busy,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              data_ready,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [CTRL_W-1:0] ctrl,
    output logic [TAG_W-1:0]  save_no,
    output logic [TAG_W-1:0]  rd_rob,
    input  logic              alu_done,
    input  logic [TAG_W-1:0]  alu_save_no
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    rs_state_e         r_state [ENTRIES];
    rs_entry_t         r_ent   [ENTRIES];
    logic              r_busy;
    logic              r_data_ready;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [CTRL_W-1:0] r_ctrl;
    logic [TAG_W-1:0]  r_save_no;
    logic [TAG_W-1:0]  r_rd_rob;

    logic [ENTRIES-1:0] w_free_req;
    logic [ENTRIES-1:0] w_rdy_req;
    logic [ENTRIES-1:0] w_hit_j;
    logic [ENTRIES-1:0] w_hit_k;
    logic [ENTRIES-1:0] w_done_vec;
    logic               w_free_found;
    logic               w_rdy_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_rdy_idx;
    logic               w_byp_j;
    logic               w_byp_k;
    logic               w_dispatch;
    logic               w_issue;
    rs_entry_t          w_new;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_free_req[i] = (r_state[i] == FREE);
            w_rdy_req[i]  = (r_state[i] == READY);
            w_hit_j[i]    = cdb_valid && (r_state[i] == WAIT) &&
                            r_ent[i].qj_busy && (r_ent[i].qj == cdb_tag);
            w_hit_k[i]    = cdb_valid && (r_state[i] == WAIT) &&
                            r_ent[i].qk_busy && (r_ent[i].qk == cdb_tag);
            // Only the EXEC entry can complete; a stray number is ignored.
            w_done_vec[i] = alu_done && (r_state[i] == EXEC) &&
                            (alu_save_no == TAG_W'(STATION_BASE + i));
        end
    end

    md_rs_pick #(.N(ENTRIES), .IDX_W(IDX_W)) u_pick_free (
        .i_req   (w_free_req),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    md_rs_pick #(.N(ENTRIES), .IDX_W(IDX_W)) u_pick_rdy (
        .i_req   (w_rdy_req),
        .o_found (w_rdy_found),
        .o_idx   (w_rdy_idx)
    );

    // Dispatch bypass: a broadcast in the dispatch cycle would otherwise be missed.
    always_comb begin
        w_byp_j       = cdb_valid && disp_qj_busy && (disp_qj == cdb_tag);
        w_byp_k       = cdb_valid && disp_qk_busy && (disp_qk == cdb_tag);
        w_new.ctrl    = disp_ctrl;
        w_new.rob     = disp_rob;
        w_new.qj      = disp_qj;
        w_new.qk      = disp_qk;
        w_new.qj_busy = disp_qj_busy && !w_byp_j;
        w_new.qk_busy = disp_qk_busy && !w_byp_k;
        w_new.vj      = w_byp_j ? cdb_value : disp_vj;
        w_new.vk      = w_byp_k ? cdb_value : disp_vk;
    end

    assign disp_ready = w_free_found && !rst;
    assign w_dispatch = disp_valid && disp_ready;
    // Issue looks at registered busy, so a done at edge N lets the next issue happen at N+1.
    assign w_issue    = !r_busy && w_rdy_found;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) r_state[i] <= FREE;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
            if (rst) begin
                r_x       <= '0;
                r_y       <= '0;
                r_ctrl    <= '0;
                r_save_no <= '0;
                r_rd_rob  <= '0;
            end
        end else begin
            r_data_ready <= 1'b0;

            for (int i = 0; i < ENTRIES; i++) begin
                if (w_hit_j[i]) begin
                    r_ent[i].vj      <= cdb_value;
                    r_ent[i].qj_busy <= 1'b0;
                end
                if (w_hit_k[i]) begin
                    r_ent[i].vk      <= cdb_value;
                    r_ent[i].qk_busy <= 1'b0;
                end
                if (r_state[i] == WAIT &&
                    !(r_ent[i].qj_busy && !w_hit_j[i]) &&
                    !(r_ent[i].qk_busy && !w_hit_k[i]))
                    r_state[i] <= READY;
                if (w_done_vec[i]) begin
                    r_state[i] <= FREE;
                    r_busy     <= 1'b0;
                end
            end

            // Dispatch targets a FREE entry, issue a READY one: never the same slot.
            if (w_dispatch) begin
                r_ent[w_free_idx]   <= w_new;
                r_state[w_free_idx] <= (w_new.qj_busy || w_new.qk_busy) ? WAIT : READY;
            end

            if (w_issue) begin
                r_state[w_rdy_idx] <= EXEC;
                r_busy             <= 1'b1;
                r_data_ready       <= 1'b1;
                r_x                <= r_ent[w_rdy_idx].vj;
                r_y                <= r_ent[w_rdy_idx].vk;
                r_ctrl             <= r_ent[w_rdy_idx].ctrl;
                r_save_no          <= TAG_W'(STATION_BASE) + TAG_W'(w_rdy_idx);
                r_rd_rob           <= r_ent[w_rdy_idx].rob;
            end
        end
    end

    assign data_ready = r_data_ready;
    assign x          = r_x;
    assign y          = r_y;
    assign ctrl       = r_ctrl;
    assign save_no    = r_save_no;
    assign rd_rob     = r_rd_rob;
endmodule

// File: tb/tb_md_reservation_station.sv
module tb_md_reservation_station;
    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [3:0]  disp_ctrl;
    logic [4:0]  disp_rob, disp_qj, disp_qk;
    logic        disp_qj_busy, disp_qk_busy;
    logic [31:0] disp_vj, disp_vk;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        data_ready;
    logic [31:0] x, y;
    logic [3:0]  ctrl;
    logic [4:0]  save_no, rd_rob;
    logic        alu_done;
    logic [4:0]  alu_save_no;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    md_reservation_station #(.ENTRIES(4), .STATION_BASE(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ctrl(disp_ctrl), .disp_rob(disp_rob),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .data_ready(data_ready), .x(x), .y(y), .ctrl(ctrl),
        .save_no(save_no), .rd_rob(rd_rob),
        .alu_done(alu_done), .alu_save_no(alu_save_no)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] c, input logic [4:0] rob,
                        input logic [31:0] vj, input logic [31:0] vk);
        disp_valid = 1'b1; disp_ctrl = c; disp_rob = rob;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
        disp_vj = vj; disp_vk = vk;
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                             input logic [3:0] ec, input logic [4:0] es, input logic [4:0] er);
        chk({tag, ".dr"}, 32'(data_ready), 32'd1);
        chk({tag, ".x"}, x, ex);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
        chk({tag, ".save_no"}, 32'(save_no), 32'(es));
        chk({tag, ".rd_rob"}, 32'(rd_rob), 32'(er));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_ctrl = '0; disp_rob = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0;
        disp_vj = '0; disp_vk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        alu_done = 1'b0; alu_save_no = '0;
        tick(); tick();

        // Reset state
        chk("rst.dr", 32'(data_ready), 32'd0);
        chk("rst.x", x, 32'd0);
        chk("rst.y", y, 32'd0);
        chk("rst.ctrl", 32'(ctrl), 32'd0);
        chk("rst.save_no", 32'(save_no), 32'd0);
        chk("rst.rd_rob", 32'(rd_rob), 32'd0);
        chk("rst.disp_ready", 32'(disp_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.disp_ready", 32'(disp_ready), 32'd1);

        // MUL with both operands valid: issue one cycle after dispatch
        disp(4'b0010, 5'd3, 32'd6, 32'd7);
        tick();
        disp_valid = 1'b0;
        chk("mul.no_early_issue", 32'(data_ready), 32'd0);
        tick();
        chk_issue("mul", 32'd6, 32'd7, 4'b0010, 5'd0, 5'd3);
        tick();
        chk("mul.pulse_one_cycle", 32'(data_ready), 32'd0);
        alu_done = 1'b1; alu_save_no = 5'd0;
        tick();
        alu_done = 1'b0;

        // DIV waiting on tag 9, woken by CDB
        disp(4'b0011, 5'd4, 32'hDEAD, 32'd4);
        disp_qj_busy = 1'b1; disp_qj = 5'd9;
        tick();
        disp_valid = 1'b0; disp_qj_busy = 1'b0;
        tick(); tick();
        chk("div.wait_no_issue", 32'(data_ready), 32'd0);
        chk("div.x_held", x, 32'd6);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'd20;
        tick();
        cdb_valid = 1'b0;
        chk("div.snoop_no_same_edge", 32'(data_ready), 32'd0);
        tick();
        chk_issue("div", 32'd20, 32'd4, 4'b0011, 5'd0, 5'd4);
        alu_done = 1'b1; alu_save_no = 5'd0;
        tick();
        alu_done = 1'b0;

        // Dispatch bypass of both operands
        disp(4'b0010, 5'd6, 32'h1111, 32'h2222);
        disp_qj_busy = 1'b1; disp_qk_busy = 1'b1; disp_qj = 5'd5; disp_qk = 5'd5;
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'd11;
        tick();
        disp_valid = 1'b0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; cdb_valid = 1'b0;
        tick();
        chk_issue("byp", 32'd11, 32'd11, 4'b0010, 5'd0, 5'd6);

        // Fill entries 1..3 while entry 0 is EXEC
        disp(4'b0010, 5'd7, 32'd1, 32'd2);
        tick();
        disp(4'b0011, 5'd8, 32'd3, 32'd4);
        tick();
        disp(4'b0101, 5'd9, 32'd5, 32'd6);   // illegal ctrl, stored unchanged
        tick();
        chk("full.disp_ready", 32'(disp_ready), 32'd0);
        disp(4'b0010, 5'd10, 32'd99, 32'd99);
        tick();
        disp_valid = 1'b0;
        chk("full.still_full", 32'(disp_ready), 32'd0);
        chk("full.busy_no_issue", 32'(data_ready), 32'd0);

        // Spurious completions: unknown number, and a READY (not EXEC) entry
        alu_done = 1'b1; alu_save_no = 5'd7;
        tick();
        alu_save_no = 5'd1;
        tick();
        alu_done = 1'b0;
        tick();
        chk("spur.no_issue", 32'(data_ready), 32'd0);
        chk("spur.still_full", 32'(disp_ready), 32'd0);

        // Complete entry 0; refill it in the very next cycle
        alu_done = 1'b1; alu_save_no = 5'd0;
        tick();
        alu_done = 1'b0;
        chk("done0.disp_ready", 32'(disp_ready), 32'd1);
        chk("done0.no_same_edge_issue", 32'(data_ready), 32'd0);
        disp(4'b0011, 5'd11, 32'd8, 32'd9);
        tick();
        disp_valid = 1'b0;
        chk_issue("e1", 32'd1, 32'd2, 4'b0010, 5'd1, 5'd7);
        tick(); tick();
        chk("e1.busy_no_issue", 32'(data_ready), 32'd0);
        alu_done = 1'b1; alu_save_no = 5'd1;
        tick();
        alu_done = 1'b0;
        tick();
        chk_issue("e0_refill", 32'd8, 32'd9, 4'b0011, 5'd0, 5'd11);
        alu_done = 1'b1; alu_save_no = 5'd0;
        tick();
        alu_done = 1'b0;
        tick();
        chk_issue("e2", 32'd3, 32'd4, 4'b0011, 5'd2, 5'd8);

        // Flush with entry 2 EXEC, entry 3 READY, plus dispatch and done in the same cycle
        flush = 1'b1;
        disp(4'b0010, 5'd12, 32'd1, 32'd1);
        alu_done = 1'b1; alu_save_no = 5'd2;
        tick();
        flush = 1'b0; disp_valid = 1'b0; alu_done = 1'b0;
        chk("flush.dr", 32'(data_ready), 32'd0);
        chk("flush.disp_ready", 32'(disp_ready), 32'd1);
        tick();
        chk("flush.no_issue1", 32'(data_ready), 32'd0);
        tick();
        chk("flush.no_issue2", 32'(data_ready), 32'd0);

        // Station works again after flush; entry 3 must not reappear
        disp(4'b0010, 5'd13, 32'd21, 32'd22);
        tick();
        disp_valid = 1'b0;
        tick();
        chk_issue("post_flush", 32'd21, 32'd22, 4'b0010, 5'd0, 5'd13);
        alu_done = 1'b1; alu_save_no = 5'd0;
        tick();
        alu_done = 1'b0;
        tick();
        chk("post_flush.empty", 32'(data_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
